// File: rtl/onewire_byte_ctl_if.sv
// onewire_byte_ctl_if: command, response and
// bit-master bus bundle for the byte controller.
interface onewire_byte_ctl_if #(
  parameter int ADW = 32
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_type;
  logic [7:0]     cmd_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [7:0]     rsp_data;
  logic           rsp_presence;
  logic           rsp_error;
  logic           ow_read;
  logic           ow_write;
  logic [ADW-1:0] ow_writedata;
  logic [ADW-1:0] ow_readdata;
  logic           ow_waitrequest;

  modport slave (
    input  cmd_valid, cmd_type, cmd_data,
    output cmd_ready,
    output rsp_valid, rsp_data,
    output rsp_presence, rsp_error,
    input  rsp_ready,
    output ow_read, ow_write, ow_writedata,
    input  ow_readdata, ow_waitrequest
  );

  modport master (
    output cmd_valid, cmd_type, cmd_data,
    input  cmd_ready,
    input  rsp_valid, rsp_data,
    input  rsp_presence, rsp_error,
    output rsp_ready,
    input  ow_read, ow_write, ow_writedata,
    output ow_readdata, ow_waitrequest
  );
endinterface

// File: rtl/onewire_byte_ctl.sv
// onewire_byte_ctl: sequences byte and reset
// commands into 1-Wire bit-master bus cycles.
module onewire_byte_ctl #(
  parameter int ADW  = 32,
  parameter int POLL = 8,
  parameter int TMO  = 1023
) (
  input logic clk,
  input logic rst,
  onewire_byte_ctl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CMD, DLY, RD, RSP
  } st_e;

  localparam int DLYN = (POLL < 1) ? 1 : POLL;
  localparam int DW   = $clog2(DLYN + 1);
  localparam int PW   = $clog2(TMO + 2);

  localparam logic [1:0] T_WR  = 2'b00;
  localparam logic [1:0] T_RD  = 2'b01;
  localparam logic [1:0] T_RST = 2'b10;

  st_e           state_q, state_d;
  logic [1:0]    type_q, type_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic [2:0]    bit_q, bit_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [7:0]    rdat_q, rdat_d;
  logic          pres_q, pres_d;
  logic          err_q, err_d;
  logic          rdy_q, rdy_d;
  logic          rv_q, rv_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [1:0]    wd_q, wd_d;

  logic wr_done;
  logic rd_done;
  logic line;
  logic cmpl;
  logic [7:0] rx_sh;
  logic unused_rd;

  assign wr_done = wr_q & ~bus.ow_waitrequest;
  assign rd_done = rd_q & ~bus.ow_waitrequest;
  assign line    = bus.ow_readdata[0];
  assign cmpl    = bus.ow_readdata[4];
  assign rx_sh   = {line, rx_q[7:1]};
  assign unused_rd = ^{bus.ow_readdata[ADW-1:5],
                       bus.ow_readdata[3:1]};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      type_q  <= 2'b00;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      bit_q   <= 3'd0;
      poll_q  <= '0;
      dly_q   <= '0;
      rdat_q  <= 8'h00;
      pres_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wd_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      poll_q  <= poll_d;
      dly_q   <= dly_d;
      rdat_q  <= rdat_d;
      pres_q  <= pres_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
    end
  end

  // Next state and datapath updates
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    poll_d  = poll_q;
    dly_d   = dly_q;
    rdat_d  = rdat_q;
    pres_d  = pres_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && rdy_q) begin
          type_d  = bus.cmd_type;
          bit_d   = 3'd0;
          poll_d  = '0;
          dly_d   = '0;
          rx_d    = 8'h00;
          rdat_d  = 8'h00;
          pres_d  = 1'b0;
          err_d   = 1'b0;
          state_d = CMD;
          unique case (bus.cmd_type)
            T_WR:  tx_d = bus.cmd_data;
            T_RD:  tx_d = 8'hFF;
            T_RST: tx_d = 8'h00;
            default: begin
              tx_d    = 8'h00;
              err_d   = 1'b1;
              state_d = RSP;
            end
          endcase
        end
      end
      CMD: begin
        if (wr_done) begin
          dly_d   = '0;
          state_d = DLY;
        end
      end
      DLY: begin
        if (dly_q == DW'(DLYN - 1)) begin
          state_d = RD;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      RD: begin
        if (rd_done && !cmpl) begin
          if (poll_q == PW'(TMO)) begin
            err_d   = 1'b1;
            state_d = RSP;
          end else begin
            poll_d  = poll_q + 1'b1;
            dly_d   = '0;
            state_d = DLY;
          end
        end else if (rd_done) begin
          poll_d = '0;
          rx_d   = rx_sh;
          tx_d   = {1'b0, tx_q[7:1]};
          if (type_q == T_RST) begin
            pres_d  = ~line;
            rdat_d  = 8'h00;
            state_d = RSP;
          end else if (bit_q == 3'd7) begin
            rdat_d  = rx_sh;
            state_d = RSP;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = CMD;
          end
        end
      end
      RSP: begin
        if (rv_q && bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs decoded from next state
  always_comb begin
    rdy_d = 1'b0;
    rv_d  = 1'b0;
    rd_d  = 1'b0;
    wr_d  = 1'b0;
    wd_d  = 2'b00;
    unique case (state_d)
      IDLE: rdy_d = 1'b1;
      CMD: begin
        wr_d = 1'b1;
        wd_d = {type_d == T_RST, tx_d[0]};
      end
      RD:  rd_d = 1'b1;
      RSP: rv_d = 1'b1;
      default: rdy_d = 1'b0;
    endcase
  end

  assign bus.cmd_ready    = rdy_q;
  assign bus.rsp_valid    = rv_q;
  assign bus.rsp_data     = rdat_q;
  assign bus.rsp_presence = pres_q;
  assign bus.rsp_error    = err_q;
  assign bus.ow_read      = rd_q;
  assign bus.ow_write     = wr_q;
  assign bus.ow_writedata = {{(ADW-2){1'b0}}, wd_q};

endmodule

// File: tb/tb_onewire_byte_ctl.sv
// tb_onewire_byte_ctl: random and directed commands
// against a wired-AND line model and scoreboard.
module tb_onewire_byte_ctl;

  localparam int ADW  = 32;
  localparam int POLL = 2;
  localparam int TMO  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  onewire_byte_ctl_if #(.ADW(ADW)) bus ();

  onewire_byte_ctl #(
    .ADW (ADW),
    .POLL(POLL),
    .TMO (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0]  data;
    logic        pres;
    logic        err;
    logic        chk;
    int          nwr;
    logic [15:0] wseq;
    int          nrd;
  } exp_t;

  exp_t exq[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  cfg_slave   = 8'hFF;
  logic        cfg_present = 1'b0;
  int          cfg_slow    = 0;
  int          stall_fix   = -1;
  int          rdly_fix    = -1;

  int          wcnt = 0;
  int          rcnt = 0;
  logic [15:0] wlog = 16'h0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Line is wired-AND of master bit and slave bit
  function automatic exp_t model(input logic [1:0] ty,
                                 input logic [7:0] d,
                                 input logic [7:0] sl,
                                 input logic pr,
                                 input int slow);
    exp_t e;
    logic [7:0] tx;
    logic tmo;
    e.data = 8'h00; e.pres = 1'b0; e.err = 1'b0;
    e.chk = 1'b1; e.nwr = 0; e.wseq = 16'h0;
    e.nrd = 0;
    tmo = (slow > TMO);
    tx = (ty == 2'd1) ? 8'hFF : d;
    if (ty == 2'd3) begin
      e.err = 1'b1;
    end else if (ty == 2'd2) begin
      e.nwr = 1;
      e.wseq = 16'h0002;
      if (tmo) begin
        e.err = 1'b1; e.chk = 1'b0; e.nrd = TMO + 1;
      end else begin
        e.pres = pr; e.nrd = slow + 1;
      end
    end else if (tmo) begin
      e.err = 1'b1; e.chk = 1'b0;
      e.nwr = 1; e.nrd = TMO + 1;
      e.wseq = {15'h0, tx[0]};
    end else begin
      e.nwr = 8;
      e.nrd = 8 * (slow + 1);
      e.data = tx & sl;
      for (int i = 0; i < 8; i++)
        e.wseq[2*i] = tx[i];
    end
    return e;
  endfunction

  // Bit-master model: stalls, logs writes, answers polls
  initial begin : bfm
    logic busy;
    int stall;
    int inc_left;
    logic line;
    logic [ADW-1:0] wd_lat;
    busy = 1'b0; stall = 0; inc_left = 0;
    line = 1'b1; wd_lat = '0;
    bus.ow_waitrequest = 1'b0;
    bus.ow_readdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy = 1'b0;
        bus.ow_waitrequest = 1'b0;
        continue;
      end
      check("rw_excl", bus.ow_read & bus.ow_write, 0);
      if (bus.ow_write || bus.ow_read) begin
        if (!busy) begin
          busy = 1'b1;
          stall = (stall_fix >= 0) ? stall_fix
                  : int'($urandom_range(0, 2));
          wd_lat = bus.ow_writedata;
        end else if (bus.ow_write) begin
          check("wd_stable", bus.ow_writedata, wd_lat);
        end
        if (stall > 0) begin
          bus.ow_waitrequest = 1'b1;
          stall--;
        end else begin
          bus.ow_waitrequest = 1'b0;
          busy = 1'b0;
          if (bus.ow_write) begin
            check("wd_upper",
                  bus.ow_writedata[ADW-1:2], 0);
            if (wcnt < 8)
              wlog[2*wcnt +: 2] = bus.ow_writedata[1:0];
            if (bus.ow_writedata[1])
              line = ~cfg_present;
            else
              line = bus.ow_writedata[0]
                     & cfg_slave[wcnt[2:0]];
            wcnt++;
            inc_left = cfg_slow;
          end else begin
            rcnt++;
            if (inc_left > 0) begin
              bus.ow_readdata = $urandom & ~32'h10;
              inc_left--;
            end else begin
              bus.ow_readdata = ($urandom & ~32'h11)
                                | 32'h10
                                | {31'h0, line};
            end
          end
        end
      end
    end
  end

  // Response monitor and scoreboard
  initial begin : mon
    logic seen;
    int rdly;
    logic [9:0] lat;
    exp_t e;
    seen = 1'b0; rdly = 0; lat = '0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.rsp_ready = 1'b0;
        seen = 1'b0;
        continue;
      end
      if (!bus.rsp_valid) begin
        bus.rsp_ready = 1'b0;
        continue;
      end
      if (!seen) begin
        seen = 1'b1;
        rdly = (rdly_fix >= 0) ? rdly_fix
               : int'($urandom_range(0, 3));
        lat = {bus.rsp_data, bus.rsp_presence,
               bus.rsp_error};
      end else begin
        check("rsp_stable", {bus.rsp_data,
              bus.rsp_presence, bus.rsp_error}, lat);
      end
      check("rdy_in_rsp", bus.cmd_ready, 0);
      if (rdly > 0) begin
        bus.rsp_ready = 1'b0;
        rdly--;
        continue;
      end
      bus.rsp_ready = 1'b1;
      seen = 1'b0;
      if (exq.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        e = exq.pop_front();
        check("rsp_error", bus.rsp_error, e.err);
        if (e.chk) begin
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_presence", bus.rsp_presence,
                e.pres);
        end
        check("n_writes", wcnt, e.nwr);
        check("write_bits", wlog, e.wseq);
        check("n_polls", rcnt, e.nrd);
        check("ow_idle_rsp",
              bus.ow_read | bus.ow_write, 0);
      end
      wcnt = 0; rcnt = 0; wlog = 16'h0;
    end
  end

  task automatic issue(input logic [1:0] ty,
                       input logic [7:0] d,
                       input logic [7:0] sl,
                       input logic pr,
                       input int slow);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_ready_wait", 0, 1);
      return;
    end
    cfg_slave = sl;
    cfg_present = pr;
    cfg_slow = slow;
    exq.push_back(model(ty, d, sl, pr, slow));
    bus.cmd_type = ty;
    bus.cmd_data = d;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_type = 2'($urandom);
    bus.cmd_data = 8'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exq.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("drain", exq.size(), 0);
  endtask

  task automatic chk_reset_vals();
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_presence", bus.rsp_presence, 0);
    check("rst_error", bus.rsp_error, 0);
    check("rst_ow_read", bus.ow_read, 0);
    check("rst_ow_write", bus.ow_write, 0);
    check("rst_writedata", bus.ow_writedata, 0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    logic [1:0] ty;
    int slow;
    bus.cmd_valid = 1'b0;
    bus.cmd_type = 2'b00;
    bus.cmd_data = 8'h00;
    #3;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_at_release", bus.cmd_ready, 0);
    @(negedge clk);
    check("ready_after_clk", bus.cmd_ready, 1);

    issue(2'd2, 8'h00, 8'h00, 1'b1, 1);
    issue(2'd0, 8'hA5, 8'hFF, 1'b0, 0);
    issue(2'd1, 8'h00, 8'h3C, 1'b0, 2);
    issue(2'd0, 8'h5A, 8'hFF, 1'b0, 255);
    drain();
    stall_fix = 5;
    rdly_fix = 3;
    issue(2'd0, 8'h96, 8'hF0, 1'b0, 1);
    drain();
    stall_fix = -1;
    rdly_fix = -1;
    issue(2'd1, 8'h00, 8'h81, 1'b0, TMO);
    issue(2'd3, 8'h77, 8'hFF, 1'b0, 0);
    issue(2'd2, 8'h00, 8'hFF, 1'b0, 0);
    drain();

    stall_fix = 3;
    issue(2'd0, 8'hC3, 8'hFF, 1'b0, 1);
    t = 0;
    @(negedge clk);
    while (!(wcnt == 3 && bus.ow_write)
           && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("reach_bit3", wcnt, 3);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals();
    exq.delete();
    wcnt = 0; rcnt = 0; wlog = 16'h0;
    stall_fix = -1;
    @(negedge clk);
    check("held_rst_ready", bus.cmd_ready, 0);
    rst = 1'b1;
    #1;
    check("ready_at_release2", bus.cmd_ready, 0);
    @(negedge clk);
    check("ready_after_clk2", bus.cmd_ready, 1);
    issue(2'd0, 8'h3E, 8'hF7, 1'b0, 1);
    drain();

    for (int i = 0; i < 40; i++) begin
      ty = 2'($urandom);
      slow = ($urandom_range(0, 9) == 0) ? 255
             : int'($urandom_range(0, TMO));
      issue(ty, 8'($urandom), 8'($urandom),
            1'($urandom), slow);
    end
    drain();
    repeat (4) @(negedge clk);
    check("final_idle", bus.cmd_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
